// File: rtl/tqvp_gera_gray_pkg.sv
// rtl/tqvp_gera_gray_pkg.sv - shared register map, STAT bit indices and Gray width
package tqvp_gera_gray_pkg;

  localparam int GRAY_W = 4;

  localparam logic [3:0] ADDR_POS    = 4'h0;
  localparam logic [3:0] ADDR_CODE   = 4'h1;
  localparam logic [3:0] ADDR_STAT   = 4'h2;
  localparam logic [3:0] ADDR_ERRCNT = 4'h3;
  localparam logic [3:0] ADDR_DEB    = 4'h4;

  localparam int STAT_VALID = 0;
  localparam int STAT_DIR   = 1;
  localparam int STAT_ERR   = 2;
  localparam int STAT_MOVED = 3;

  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/tqvp_gera_gray2bin.sv
// rtl/tqvp_gera_gray2bin.sv - parameterised combinational Gray-to-binary decoder
module tqvp_gera_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/tqvp_gera_gray_tracker.sv
// rtl/tqvp_gera_gray_tracker.sv - debounced Gray encoder tracker with position/error registers
module tqvp_gera_gray_tracker
  import tqvp_gera_gray_pkg::*;
#(
  parameter logic [7:0] DEB_RESET = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [GRAY_W-1:0] gray_in;
  logic [GRAY_W-1:0] cand;
  logic [GRAY_W-1:0] stable;
  logic [GRAY_W-1:0] bin_new;
  logic [GRAY_W-1:0] bin_old;
  logic [GRAY_W-1:0] delta;
  logic [7:0]        cnt;
  logic [7:0]        pos;
  logic [7:0]        errcnt;
  logic [7:0]        deb;
  logic [7:0]        deb_eff;
  logic              valid;
  logic              dir;
  logic              err;
  logic              moved;
  logic              commit;
  logic              step_up;
  logic              step_dn;
  logic              jump_err;
  logic              wr_pos;
  logic              wr_stat;
  logic              wr_errcnt;
  logic              wr_deb;
  logic [7:0]        stat;
  logic              unused_ui;

  assign gray_in   = ui_in[GRAY_W-1:0];
  assign unused_ui = &{1'b0, ui_in[7:GRAY_W]};

  tqvp_gera_gray2bin #(.W(GRAY_W)) u_dec_new (
    .gray (cand),
    .bin  (bin_new)
  );

  tqvp_gera_gray2bin #(.W(GRAY_W)) u_dec_old (
    .gray (stable),
    .bin  (bin_old)
  );

  // A stored debounce length of zero behaves as one.
  assign deb_eff = (deb == 8'd0) ? 8'd1 : deb;
  assign commit  = (cnt >= deb_eff) && ((cand != stable) || !valid);
  assign delta   = bin_new - bin_old;

  assign step_up  = commit && valid && (delta == 4'd1);
  assign step_dn  = commit && valid && (delta == 4'hF);
  assign jump_err = commit && valid && !step_up && !step_dn;

  assign wr_pos    = data_write && (address == ADDR_POS);
  assign wr_stat   = data_write && (address == ADDR_STAT);
  assign wr_errcnt = data_write && (address == ADDR_ERRCNT);
  assign wr_deb    = data_write && (address == ADDR_DEB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand   <= '0;
      cnt    <= 8'd0;
      stable <= '0;
      pos    <= 8'd0;
      valid  <= 1'b0;
      dir    <= 1'b0;
      err    <= 1'b0;
      moved  <= 1'b0;
      errcnt <= 8'd0;
      deb    <= DEB_RESET;
    end else begin
      if (gray_in != cand) begin
        cand <= gray_in;
        cnt  <= 8'd1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end

      if (commit) begin
        stable <= cand;
        valid  <= 1'b1;
      end

      // A register write beats a coincident step on POS.
      if (wr_pos) begin
        pos <= data_in;
      end else if (step_up) begin
        pos <= pos + 8'd1;
      end else if (step_dn) begin
        pos <= pos - 8'd1;
      end

      if (step_up) begin
        dir <= 1'b1;
      end else if (step_dn) begin
        dir <= 1'b0;
      end

      // W1C clears, but a same-edge set event wins.
      err   <= (err   & ~(wr_stat & data_in[STAT_ERR]))   | jump_err;
      moved <= (moved & ~(wr_stat & data_in[STAT_MOVED])) | step_up | step_dn;

      if (wr_errcnt) begin
        errcnt <= 8'd0;
      end else if (jump_err && (errcnt != CNT_MAX)) begin
        errcnt <= errcnt + 8'd1;
      end

      if (wr_deb) begin
        deb <= data_in;
      end
    end
  end

  always_comb begin
    stat             = 8'd0;
    stat[STAT_VALID] = valid;
    stat[STAT_DIR]   = dir;
    stat[STAT_ERR]   = err;
    stat[STAT_MOVED] = moved;
  end

  always_comb begin
    data_out = 8'd0;
    case (address)
      ADDR_POS:    data_out = pos;
      ADDR_CODE:   data_out = {{(8-GRAY_W){1'b0}}, bin_old};
      ADDR_STAT:   data_out = stat;
      ADDR_ERRCNT: data_out = errcnt;
      ADDR_DEB:    data_out = deb;
      default:     data_out = 8'd0;
    endcase
  end

  assign uo_out = pos;

endmodule

// File: tb/tb_tqvp_gera_gray_tracker.sv
// tb/tb_tqvp_gera_gray_tracker.sv - directed and randomized checks against a sample-history model
module tb_tqvp_gera_gray_tracker;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  tqvp_gera_gray_tracker #(.DEB_RESET(8'd16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: the raw sample history since reset decides commits.
  logic [3:0] hist[$];
  logic [7:0] m_pos, m_errcnt, m_deb;
  logic [3:0] m_stable;
  logic       m_valid, m_dir, m_err, m_moved;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    case (a)
      4'h0:    return m_pos;
      4'h1:    return {4'b0, g2b(m_stable)};
      4'h2:    return {4'b0, m_moved, m_err, m_dir, m_valid};
      4'h3:    return m_errcnt;
      4'h4:    return m_deb;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    int         deff;
    int         diff;
    int         step;
    bit         commit;
    bit         err_ev;
    logic [3:0] v;
    if (!rst_n) begin
      hist.delete();
      m_pos = 0; m_errcnt = 0; m_deb = 8'd16; m_stable = 0;
      m_valid = 0; m_dir = 0; m_err = 0; m_moved = 0;
    end else begin
      deff   = (m_deb == 0) ? 1 : int'(m_deb);
      commit = 0;
      step   = 0;
      err_ev = 0;
      v      = 4'h0;
      if (hist.size() >= deff) begin
        v      = hist[hist.size()-1];
        commit = 1;
        for (int k = 0; k < deff; k++)
          if (hist[hist.size()-1-k] != v) commit = 0;
        if (m_valid && v == m_stable) commit = 0;
      end
      if (commit) begin
        if (m_valid) begin
          diff = (int'(g2b(v)) - int'(g2b(m_stable)) + 16) % 16;
          if (diff == 1) step = 1;
          else if (diff == 15) step = -1;
          else err_ev = 1;
        end
        m_valid  = 1;
        m_stable = v;
      end
      if (data_write && address == 4'h0) m_pos = data_in;
      else if (step == 1) m_pos = m_pos + 8'd1;
      else if (step == -1) m_pos = m_pos - 8'd1;
      if (step == 1) m_dir = 1;
      if (step == -1) m_dir = 0;
      if (data_write && address == 4'h2 && data_in[2]) m_err = 0;
      if (data_write && address == 4'h2 && data_in[3]) m_moved = 0;
      if (err_ev) m_err = 1;
      if (step != 0) m_moved = 1;
      if (data_write && address == 4'h3) m_errcnt = 0;
      else if (err_ev && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
      if (data_write && address == 4'h4) m_deb = data_in;
      hist.push_back(ui_in[3:0]);
      if (hist.size() > 256) void'(hist.pop_front());
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("cyc_uo_out", uo_out, m_pos);
    check("cyc_data_out", data_out, m_read(address));
  end

  task automatic hold(input logic [3:0] g, input int n);
    ui_in = {4'h0, g};
    repeat (n) @(negedge clk);
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic expect_reg(input logic [3:0] a, input logic [7:0] exp, input string name);
    address = a;
    #1;
    check(name, data_out, exp);
  endtask

  task automatic rhold(input logic [3:0] g, input int n);
    repeat (n) begin
      ui_in      = {4'($urandom_range(0, 15)), g};
      address    = 4'($urandom_range(0, 15));
      data_write = ($urandom_range(0, 15) == 0);
      data_in    = 8'($urandom_range(0, 255));
      if (data_write) begin
        address = 4'($urandom_range(0, 5));
        if (address == 4'h4) data_in = 8'($urandom_range(0, 6));
      end
      rst_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    data_write = 1'b0;
    rst_n      = 1'b1;
  endtask

  initial begin
    logic [3:0] cur_b;
    logic [3:0] nb;
    int         r;
    rst_n = 1'b0; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    expect_reg(4'h0, 8'h00, "rst_pos");
    expect_reg(4'h2, 8'h00, "rst_stat");
    expect_reg(4'h3, 8'h00, "rst_errcnt");
    expect_reg(4'h4, 8'h10, "rst_deb");
    check("rst_uo_out", uo_out, 8'h00);
    rst_n = 1'b1;

    hold(4'h0, 16);
    expect_reg(4'h2, 8'h00, "first_commit_not_yet");
    hold(4'h0, 1);
    expect_reg(4'h2, 8'h01, "first_commit_valid");
    expect_reg(4'h0, 8'h00, "first_commit_pos");

    hold(4'h1, 20); hold(4'h3, 20); hold(4'h2, 20);
    expect_reg(4'h0, 8'h03, "up3_pos");
    expect_reg(4'h1, 8'h03, "up3_code");
    expect_reg(4'h2, 8'h0B, "up3_stat");
    hold(4'h3, 20);
    expect_reg(4'h0, 8'h02, "back_pos");
    expect_reg(4'h2, 8'h09, "back_stat");

    hold(4'h2, 5); hold(4'h3, 20);
    expect_reg(4'h0, 8'h02, "glitch_pos");

    hold(4'h1, 20); hold(4'h0, 20); hold(4'h6, 20);
    expect_reg(4'h2, 8'h0D, "jump_stat");
    expect_reg(4'h3, 8'h01, "jump_errcnt");
    expect_reg(4'h0, 8'h00, "jump_pos");
    write_reg(4'h2, 8'h04);
    expect_reg(4'h2, 8'h09, "w1c_err");

    write_reg(4'h0, 8'h7F);
    hold(4'h7, 20);
    expect_reg(4'h0, 8'h80, "wrap_up");
    hold(4'h0, 20); hold(4'h8, 20);
    expect_reg(4'h0, 8'h7F, "wrap_down");
    expect_reg(4'h3, 8'h02, "wrap_errcnt");

    hold(4'h9, 16);
    write_reg(4'h0, 8'h55);
    expect_reg(4'h0, 8'h55, "poswr_commit_pos");
    expect_reg(4'h1, 8'h0E, "poswr_commit_code");
    expect_reg(4'h2, 8'h0D, "poswr_commit_stat");

    write_reg(4'h4, 8'h00);
    hold(4'h8, 1);
    write_reg(4'h0, 8'h22);
    expect_reg(4'h0, 8'h22, "deb0_poswr_pos");
    expect_reg(4'h1, 8'h0F, "deb0_poswr_code");
    expect_reg(4'h2, 8'h0F, "deb0_poswr_stat");
    hold(4'h0, 1);
    expect_reg(4'h0, 8'h22, "deb0_one_edge");
    hold(4'h0, 1);
    expect_reg(4'h0, 8'h23, "deb0_two_edges");

    for (int i = 0; i < 130; i++) begin
      hold(4'h6, 2); hold(4'h0, 2);
    end
    expect_reg(4'h3, 8'hFF, "errcnt_sat");
    expect_reg(4'h0, 8'h23, "errcnt_sat_pos");
    hold(4'h6, 1);
    write_reg(4'h3, 8'hAA);
    expect_reg(4'h3, 8'h00, "errcnt_wr_vs_err");

    cur_b = g2b(4'h6);
    for (int seg = 0; seg < 250; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        nb = ($urandom_range(0, 1) == 1) ? cur_b + 4'd1 : cur_b - 4'd1;
        cur_b = nb;
      end else if (r < 80) begin
        cur_b = 4'($urandom_range(0, 15));
      end else begin
        rhold(b2g(4'($urandom_range(0, 15))), $urandom_range(1, 3));
      end
      rhold(b2g(cur_b), $urandom_range(1, 20));
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
